clk_freq_monitor: RTL



---
 rtl/clk_freq_monitor.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/clk_freq_monitor.sv
// Measures the period of an asynchronous monitored clock in clk cycles,
// declares lock after a run of in-window periods, and flags frequency errors and clock loss.
module clk_freq_monitor #(
  parameter int EXPECTED_PERIOD = 4,
  parameter int TOLERANCE       = 0,
  parameter int LOCK_COUNT      = 4,
  parameter int TIMEOUT         = 16,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mon_clk,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             freq_err,
  output logic             clk_lost
);

  localparam int GW    = $clog2(LOCK_COUNT + 1);
  localparam int LO_I  = (EXPECTED_PERIOD > TOLERANCE) ? (EXPECTED_PERIOD - TOLERANCE) : 0;
  localparam int HI_I  = EXPECTED_PERIOD + TOLERANCE;
  localparam logic [CNT_W:0]   WIN_LO = (CNT_W+1)'(LO_I);
  localparam logic [CNT_W:0]   WIN_HI = (CNT_W+1)'(HI_I);
  localparam logic [CNT_W-1:0] TMO    = CNT_W'(TIMEOUT);
  localparam logic [GW-1:0]    LC_G   = GW'(LOCK_COUNT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  logic             r_s1, r_s2, r_s3;
  logic [CNT_W-1:0] r_cnt;
  state_t           r_state;
  logic [GW-1:0]    r_good;
  logic [CNT_W-1:0] r_period;
  logic             r_pv, r_ferr, r_lost, r_locked;

  logic             w_rise, w_in_win, w_timeout, w_cnt_max;
  logic [CNT_W:0]   w_cnt_ext;
  logic [GW-1:0]    w_good_inc;
  state_t           w_state_nxt;
  logic [GW-1:0]    w_good_nxt;
  logic [CNT_W-1:0] w_period_nxt;
  logic             w_pv_nxt, w_ferr_nxt, w_lost_nxt, w_locked_nxt;

  assign w_rise     = r_s2 & ~r_s3;
  assign w_cnt_ext  = {1'b0, r_cnt};
  assign w_in_win   = (w_cnt_ext >= WIN_LO) && (w_cnt_ext <= WIN_HI);
  assign w_timeout  = (r_cnt == TMO) && !w_rise;
  assign w_cnt_max  = &r_cnt;
  assign w_good_inc = r_good + 1'b1;

  // Edge synchroniser and saturating period counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_s3  <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s1 <= mon_clk;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      if (w_rise) begin
        r_cnt <= CNT_W'(1);
      end else if (!w_cnt_max) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  // State register and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_good   <= '0;
      r_period <= '0;
      r_pv     <= 1'b0;
      r_ferr   <= 1'b0;
      r_lost   <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_good   <= w_good_nxt;
      r_period <= w_period_nxt;
      r_pv     <= w_pv_nxt;
      r_ferr   <= w_ferr_nxt;
      r_lost   <= w_lost_nxt;
      r_locked <= w_locked_nxt;
    end
  end

  // Next-state logic; a rise coinciding with the timeout count is measured, not treated as loss
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_state_nxt = MEASURE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      MEASURE: begin
        if (w_rise) begin
          if (w_in_win && (w_good_inc == LC_G)) begin
            w_state_nxt = LOCKED;
          end else begin
            w_state_nxt = MEASURE;
          end
        end else if (w_timeout) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = MEASURE;
        end
      end
      LOCKED: begin
        if (w_rise) begin
          if (w_in_win) begin
            w_state_nxt = LOCKED;
          end else begin
            w_state_nxt = MEASURE;
          end
        end else if (w_timeout) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = LOCKED;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs and the good-period run length
  always_comb begin
    w_good_nxt   = r_good;
    w_period_nxt = r_period;
    w_pv_nxt     = 1'b0;
    w_ferr_nxt   = 1'b0;
    w_lost_nxt   = r_lost;
    case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_good_nxt = '0;
          w_lost_nxt = 1'b0;
        end else begin
          w_good_nxt = r_good;
        end
      end
      MEASURE, LOCKED: begin
        if (w_rise) begin
          w_period_nxt = r_cnt;
          w_pv_nxt     = 1'b1;
          if (!w_in_win) begin
            w_good_nxt = '0;
            w_ferr_nxt = (r_state == LOCKED);
          end else if (r_state == MEASURE) begin
            w_good_nxt = w_good_inc;
          end else begin
            w_good_nxt = r_good;
          end
        end else if (w_timeout) begin
          w_lost_nxt = 1'b1;
        end else begin
          w_lost_nxt = r_lost;
        end
      end
      default: w_good_nxt = '0;
    endcase
    w_locked_nxt = (w_state_nxt == LOCKED);
  end

  assign period       = r_period;
  assign period_valid = r_pv;
  assign freq_err     = r_ferr;
  assign clk_lost     = r_lost;
  assign locked       = r_locked;

endmodule
